// File: rtl/mux_demux_pkg.sv
// Shared definitions for the 16:1 mux and its write-side slot bank.
// Widths, slot index type and the flattened slot-slice helper.
package mux_demux_pkg;

    localparam int DATA_W = 4;
    localparam int SEL_W  = 4;
    localparam int NSLOT  = 16;

    typedef logic [SEL_W-1:0] slot_idx_t;

    function automatic logic [DATA_W-1:0] slot_get(
        input logic [NSLOT*DATA_W-1:0] flat,
        input slot_idx_t               k
    );
        return flat[k*DATA_W +: DATA_W];
    endfunction

endpackage

// File: rtl/dec4to16_en.sv
// One-hot index decoder with enable.
// Produces per-slot write enables for the slot bank.
module dec4to16_en #(
    parameter int SEL_W = 4
) (
    input  logic                  en,
    input  logic [SEL_W-1:0]      sel,
    output logic [(2**SEL_W)-1:0] onehot
);

    // Single hot bit at the selected index when enabled.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/demux1to16_4bit_bank.sv
// Sixteen registered 4-bit slots written over valid/ready.
// Addressed or auto-pointer mode; flattened slot export.
module demux1to16_4bit_bank #(
    parameter int DATA_W = mux_demux_pkg::DATA_W,
    parameter int SEL_W  = mux_demux_pkg::SEL_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_W-1:0]              in_data,
    input  logic [SEL_W-1:0]               in_sel,
    input  logic                           auto_mode,
    input  logic                           clear,
    output logic [(2**SEL_W)*DATA_W-1:0]   slot_data,
    output logic [(2**SEL_W)-1:0]          slot_valid,
    output logic [SEL_W-1:0]               wr_ptr,
    output logic                           full,
    output logic                           wr_done,
    output logic [SEL_W-1:0]               wr_done_sel
);

    import mux_demux_pkg::*;

    localparam int NUM_SLOTS = 2**SEL_W;

    logic [NUM_SLOTS*DATA_W-1:0] slot_q, slot_d;
    logic [NUM_SLOTS-1:0]        valid_q, valid_d;
    logic [SEL_W-1:0]            ptr_q, ptr_d;
    logic                        done_q, done_d;
    logic [SEL_W-1:0]            done_sel_q, done_sel_d;

    logic                        accept;
    logic [SEL_W-1:0]            tgt;
    logic [NUM_SLOTS-1:0]        we;

    assign full     = &valid_q;
    assign in_ready = !clear && !(auto_mode && full);
    assign accept   = in_valid && in_ready;
    assign tgt      = auto_mode ? ptr_q : in_sel;

    dec4to16_en #(
        .SEL_W (SEL_W)
    ) u_dec (
        .en     (accept),
        .sel    (tgt),
        .onehot (we)
    );

    // Next-state: clear wins, otherwise apply the decoded write.
    always_comb begin
        slot_d     = slot_q;
        valid_d    = valid_q;
        ptr_d      = ptr_q;
        done_d     = accept;
        done_sel_d = accept ? tgt : done_sel_q;
        if (clear) begin
            slot_d  = '0;
            valid_d = '0;
            ptr_d   = '0;
        end else begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                if (we[k]) begin
                    slot_d[k*DATA_W +: DATA_W] = in_data;
                    valid_d[k]                 = 1'b1;
                end
            end
            if (accept && auto_mode) begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    // Bank, flags, pointer and done registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q     <= '0;
            valid_q    <= '0;
            ptr_q      <= '0;
            done_q     <= 1'b0;
            done_sel_q <= '0;
        end else begin
            slot_q     <= slot_d;
            valid_q    <= valid_d;
            ptr_q      <= ptr_d;
            done_q     <= done_d;
            done_sel_q <= done_sel_d;
        end
    end

    assign slot_data   = slot_q;
    assign slot_valid  = valid_q;
    assign wr_ptr      = ptr_q;
    assign wr_done     = done_q;
    assign wr_done_sel = done_sel_q;

endmodule
